// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage memory access controller: RV32I funct3,
// data_memory modeAddr values, FSM states and the request decoder.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] MODE_NONE = 3'b000;
    localparam logic [2:0] MODE_W    = 3'b001;
    localparam logic [2:0] MODE_H    = 3'b010;
    localparam logic [2:0] MODE_B    = 3'b011;
    localparam logic [2:0] MODE_HU   = 3'b100;
    localparam logic [2:0] MODE_BU   = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef struct packed {
        logic [2:0] mode;
        logic       illegal;
        logic       misaligned;
    } decode_t;

    // Illegal wins over misaligned; a rejected request never carries a mode.
    function automatic decode_t decode(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        decode_t d;
        d.mode       = MODE_NONE;
        d.illegal    = 1'b0;
        d.misaligned = 1'b0;
        case (funct3)
            F3_B: d.mode = MODE_B;
            F3_H: begin
                d.mode       = MODE_H;
                d.misaligned = addr_lo[0];
            end
            F3_W: begin
                d.mode       = MODE_W;
                d.misaligned = |addr_lo;
            end
            F3_BU: begin
                if (we) d.illegal = 1'b1;
                else    d.mode    = MODE_BU;
            end
            F3_HU: begin
                if (we) begin
                    d.illegal = 1'b1;
                end else begin
                    d.mode       = MODE_HU;
                    d.misaligned = addr_lo[0];
                end
            end
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal) begin
            d.mode       = MODE_NONE;
            d.misaligned = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Initiator-side load/store controller between the MEM stage and data_memory:
// valid/ready request, decode + alignment check, held memory access, registered response.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_misaligned,
    output logic             rsp_illegal,
    output logic             stall,
    output logic [2:0]       mem_modeAddr,
    output logic [WIDTH-1:0] mem_A,
    output logic [WIDTH-1:0] mem_WD,
    output logic             mem_WE,
    input  logic [WIDTH-1:0] mem_RD
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t           state, state_nxt;
    logic [3:0]       count, count_nxt;
    logic             lat_we;
    logic [2:0]       lat_mode;
    logic [WIDTH-1:0] lat_addr;
    logic [WIDTH-1:0] lat_wdata;
    logic [WIDTH-1:0] rdata_q;
    logic             mis_q;
    logic             ill_q;

    decode_t dec;
    logic    accept;
    logic    dec_err;
    logic    commit;

    assign dec     = decode(req_we, req_funct3, req_addr[1:0]);
    assign dec_err = dec.illegal | dec.misaligned;
    assign accept  = (state == IDLE) && req_valid;
    assign commit  = (state == ACCESS) && (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (dec_err) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = ACCESS;
                        count_nxt = WAIT_INIT;
                    end
                end
            end
            ACCESS: begin
                if (count == '0) state_nxt = RESP;
                else             count_nxt = count - 4'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch and response registers; rsp_* hold until the next response.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_mode  <= MODE_NONE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            mis_q     <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_mode  <= dec.mode;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                if (dec_err) begin
                    rdata_q <= '0;
                    mis_q   <= dec.misaligned;
                    ill_q   <= dec.illegal;
                end
            end
            if (commit) begin
                rdata_q <= lat_we ? '0 : mem_RD;
                mis_q   <= 1'b0;
                ill_q   <= 1'b0;
            end
        end
    end

    always_comb begin
        req_ready      = (state == IDLE);
        stall          = req_valid && (state != IDLE);
        rsp_valid      = (state == RESP);
        rsp_rdata      = rdata_q;
        rsp_misaligned = mis_q;
        rsp_illegal    = ill_q;
        mem_modeAddr   = MODE_NONE;
        mem_A          = '0;
        mem_WD         = '0;
        // Gated by rst so a commit coinciding with reset never writes.
        mem_WE         = commit && lat_we && !rst;
        if (state == ACCESS) begin
            mem_modeAddr = lat_mode;
            mem_A        = lat_addr;
            mem_WD       = lat_wdata;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: three controllers (WAIT_CYCLES 0/1/3) share one stimulus stream,
// each with its own data_memory model; a cycle-level reference predicts every output.
module tb_mem_access_ctrl;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        trigger;

    logic        rdy     [N];
    logic        stall_w [N];
    logic        rv      [N];
    logic        mis     [N];
    logic        ill     [N];
    logic        we_w    [N];
    logic [31:0] rdata   [N];
    logic [31:0] ma      [N];
    logic [31:0] mwd     [N];
    logic [31:0] mrd     [N];
    logic [2:0]  mmode   [N];

    int checks = 0;
    int errors = 0;
    int now    = 0;

    always #5 clk = ~clk;

    function automatic int wv(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    function automatic logic [7:0] fill(input int g, input int i);
        return 8'((i * 7 + g * 31 + 90) & 255);
    endfunction

    function automatic logic [31:0] env_rd(input logic [2:0] m, input logic [31:0] w,
                                           input logic trig, input logic [31:0] a);
        if (a == 32'h100) return {31'b0, trig};
        case (m)
            3'b001:  return w;
            3'b010:  return {{16{w[15]}}, w[15:0]};
            3'b011:  return {{24{w[7]}}, w[7:0]};
            3'b100:  return {16'b0, w[15:0]};
            3'b101:  return {24'b0, w[7:0]};
            default: return 32'b0;
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : gen_dut
        logic [7:0]  mem [4096];
        logic [11:0] ix;
        logic [31:0] w;
        assign ix     = ma[g][11:0];
        assign w      = {mem[ix + 12'd3], mem[ix + 12'd2], mem[ix + 12'd1], mem[ix]};
        assign mrd[g] = env_rd(mmode[g], w, trigger, ma[g]);

        initial for (int i = 0; i < 4096; i++) mem[i] = fill(g, i);

        always @(posedge clk) begin
            if (we_w[g]) begin
                case (mmode[g])
                    3'b001: begin
                        mem[ix]         <= mwd[g][7:0];
                        mem[ix + 12'd1] <= mwd[g][15:8];
                        mem[ix + 12'd2] <= mwd[g][23:16];
                        mem[ix + 12'd3] <= mwd[g][31:24];
                    end
                    3'b010: begin
                        mem[ix]         <= mwd[g][7:0];
                        mem[ix + 12'd1] <= mwd[g][15:8];
                    end
                    3'b011:  mem[ix] <= mwd[g][7:0];
                    default: ;
                endcase
            end
        end

        mem_access_ctrl #(
            .WIDTH      (32),
            .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .req_valid     (req_valid),
            .req_ready     (rdy[g]),
            .req_we        (req_we),
            .req_funct3    (req_funct3),
            .req_addr      (req_addr),
            .req_wdata     (req_wdata),
            .rsp_valid     (rv[g]),
            .rsp_rdata     (rdata[g]),
            .rsp_misaligned(mis[g]),
            .rsp_illegal   (ill[g]),
            .stall         (stall_w[g]),
            .mem_modeAddr  (mmode[g]),
            .mem_A         (ma[g]),
            .mem_WD        (mwd[g]),
            .mem_WE        (we_w[g]),
            .mem_RD        (mrd[g])
        );
    end

    // Reference: golden byte store plus per-controller transaction timing.
    logic [7:0]  gmem    [N][4096];
    logic        m_busy  [N];
    int          m_trsp  [N];
    logic        m_err   [N];
    logic        m_store [N];
    logic [2:0]  m_f3    [N];
    logic [31:0] m_addr  [N];
    logic [31:0] m_wdata [N];
    logic [31:0] h_rdata [N];
    logic        h_mis   [N];
    logic        h_ill   [N];

    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [2:0] ref_mode(input logic [2:0] f3);
        case (f3)
            3'd0:    return 3'd3;
            3'd1:    return 3'd2;
            3'd2:    return 3'd1;
            3'd4:    return 3'd5;
            3'd5:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic ref_legal(input logic we, input logic [2:0] f3);
        if (we) return f3 <= 3'd2;
        return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic [31:0] ref_load(input int d);
        int          base;
        logic [31:0] v;
        if (m_addr[d] == 32'h100) return {31'b0, trigger};
        base = int'(m_addr[d][11:0]);
        v = 0;
        for (int k = 0; k < ref_size(m_f3[d]); k++) v = v + (32'(gmem[d][base + k]) << (8 * k));
        if (m_f3[d] == 3'd0 && v[7])  v = v - 32'd256;
        if (m_f3[d] == 3'd1 && v[15]) v = v - 32'd65536;
        return v;
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cycle=%0d observed=%h expected=%h", tag, d, now, obs, exp);
        end
    endtask

    task automatic check_cycle();
        for (int d = 0; d < N; d++) begin
            logic active, acc, cm;
            active = m_busy[d] && (now <= m_trsp[d]);
            acc    = active && !m_err[d] && (now < m_trsp[d]);
            cm     = acc && m_store[d] && (now == m_trsp[d] - 1);
            chk("req_ready", d, 32'(rdy[d]), 32'(!active));
            chk("stall", d, 32'(stall_w[d]), 32'(req_valid && active));
            chk("rsp_valid", d, 32'(rv[d]), 32'(active && now == m_trsp[d]));
            chk("rsp_rdata", d, rdata[d], h_rdata[d]);
            chk("rsp_misaligned", d, 32'(mis[d]), 32'(h_mis[d]));
            chk("rsp_illegal", d, 32'(ill[d]), 32'(h_ill[d]));
            chk("mem_modeAddr", d, 32'(mmode[d]), acc ? 32'(ref_mode(m_f3[d])) : 32'd0);
            chk("mem_A", d, ma[d], acc ? m_addr[d] : 32'd0);
            chk("mem_WD", d, mwd[d], acc ? m_wdata[d] : 32'd0);
            chk("mem_WE", d, 32'(we_w[d]), 32'(cm && !rst));
        end
    endtask

    task automatic advance();
        for (int d = 0; d < N; d++) begin
            logic active;
            active = m_busy[d] && (now <= m_trsp[d]);
            if (rst) begin
                m_busy[d]  = 1'b0;
                h_rdata[d] = 0;
                h_mis[d]   = 1'b0;
                h_ill[d]   = 1'b0;
            end else begin
                if (active && !m_err[d] && now == m_trsp[d] - 1) begin
                    if (m_store[d]) begin
                        for (int k = 0; k < ref_size(m_f3[d]); k++)
                            gmem[d][int'(m_addr[d][11:0]) + k] = m_wdata[d][8*k +: 8];
                        h_rdata[d] = 0;
                    end else begin
                        h_rdata[d] = ref_load(d);
                    end
                    h_mis[d] = 1'b0;
                    h_ill[d] = 1'b0;
                end
                if (!active && req_valid) begin
                    logic legal, aligned;
                    legal      = ref_legal(req_we, req_funct3);
                    aligned    = (req_addr % ref_size(req_funct3)) == 0;
                    m_busy[d]  = 1'b1;
                    m_store[d] = req_we;
                    m_f3[d]    = req_funct3;
                    m_addr[d]  = req_addr;
                    m_wdata[d] = req_wdata;
                    m_err[d]   = !legal || !aligned;
                    m_trsp[d]  = now + (m_err[d] ? 1 : wv(d) + 2);
                    if (m_err[d]) begin
                        h_rdata[d] = 0;
                        h_ill[d]   = !legal;
                        h_mis[d]   = legal && !aligned;
                    end
                end
            end
        end
        now++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        int          pulses;
        logic [31:0] prior;
        for (int d = 0; d < N; d++) begin
            m_busy[d]  = 1'b0;
            m_trsp[d]  = 0;
            m_err[d]   = 1'b0;
            m_store[d] = 1'b0;
            m_f3[d]    = 3'd0;
            m_addr[d]  = 0;
            m_wdata[d] = 0;
            h_rdata[d] = 0;
            h_mis[d]   = 1'b0;
            h_ill[d]   = 1'b0;
            for (int i = 0; i < 4096; i++) gmem[d][i] = fill(d, i);
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 0; req_wdata = 0; trigger = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        do_req(1'b1, 3'd0, 32'h0001_0003, 32'h0000_00A5);
        do_req(1'b0, 3'd4, 32'h0001_0003, 32'h0);
        chk("lbu_a5", 1, rdata[1], 32'h0000_00A5);
        do_req(1'b0, 3'd0, 32'h0001_0003, 32'h0);
        chk("lb_a5", 1, rdata[1], 32'hFFFF_FFA5);

        do_req(1'b0, 3'd2, 32'h0001_0002, 32'h0);
        chk("lw_misaligned", 0, 32'(mis[0]), 32'd1);
        do_req(1'b1, 3'd1, 32'h0001_0001, 32'h1234_5678);
        chk("sh_misaligned", 2, 32'(mis[2]), 32'd1);
        do_req(1'b0, 3'd3, 32'h0001_0004, 32'h0);
        chk("f3_011_illegal", 1, 32'(ill[1]), 32'd1);
        do_req(1'b1, 3'd4, 32'h0001_0004, 32'h55);
        chk("sb_f3_100_illegal", 0, 32'(ill[0]), 32'd1);

        trigger = 1'b1;
        do_req(1'b0, 3'd2, 32'h0000_0100, 32'h0);
        chk("trigger_1", 1, rdata[1], 32'h1);
        trigger = 1'b0;
        do_req(1'b0, 3'd2, 32'h0000_0100, 32'h0);
        chk("trigger_0", 1, rdata[1], 32'h0);

        // Store on the WAIT_CYCLES=3 controller cut by reset in its commit cycle.
        prior = {fill(2, 16'h13), fill(2, 16'h12), fill(2, 16'h11), fill(2, 16'h10)};
        req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h0001_0010; req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ready_after_rst", 2, 32'(rdy[2]), 32'd1);
        repeat (4) tick();
        do_req(1'b0, 3'd2, 32'h0001_0010, 32'h0);
        chk("lw_prior", 2, rdata[2], prior);
        chk("lw_written", 0, rdata[0], 32'hDEAD_BEEF);

        req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0001_0010; req_valid = 1'b1;
        pulses = 0;
        repeat (9) begin
            tick();
            if (rv[0]) pulses++;
        end
        req_valid = 1'b0;
        repeat (6) tick();
        chk("b2b_pulses", 0, 32'(pulses), 32'd3);

        repeat (300) begin
            req_valid  = ($urandom % 3) != 0;
            rst        = ($urandom % 97) == 0;
            req_we     = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = 32'h0001_0000 | $urandom_range(32'h200, 32'hFFC);
            req_wdata  = $urandom;
            tick();
        end
        rst = 1'b0; req_valid = 1'b0;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator-side controller that sits between the MEM pipeline stage and data_memory.
- Accepts one load/store request at a time over a valid/ready handshake.
- Translates RV32I funct3 into the memory's modeAddr encoding and checks alignment.
- Drives the memory port for a programmable number of wait cycles, then returns a registered response.
- Replaces direct combinational wiring of the MEM stage to memory, so slower memory models can be inserted behind it.

Parameters:
WIDTH, 32, data/address width
WAIT_CYCLES, 1, extra cycles the memory port is held before write commit / read sample; legal 0..15

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  WIDTH  byte address
req_wdata  in  WIDTH  store data (low bits used for SB/SH)
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  WIDTH  load result (0 for stores/errors)
rsp_misaligned  out  1  request rejected, misaligned
rsp_illegal  out  1  request rejected, bad funct3
stall  out  1  req_valid && !req_ready
mem_modeAddr  out  3  to data_memory modeAddr
mem_A  out  WIDTH  to data_memory A
mem_WD  out  WIDTH  to data_memory WD
mem_WE  out  1  to data_memory WE
mem_RD  in  WIDTH  from data_memory RD

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset values: state=IDLE, counter=0, all request registers 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_misaligned=0, rsp_illegal=0, mem_modeAddr=000, mem_A=0, mem_WD=0, mem_WE=0.
- States:
  - IDLE: req_ready=1. On req_valid at a clock edge, latch we/funct3/addr/wdata and decode.
    - Legal and aligned → ACCESS, with counter loaded to WAIT_CYCLES.
    - Otherwise → RESP, with the matching error flag set and rdata=0.
  - ACCESS: req_ready=0. mem_modeAddr, mem_A and mem_WD are driven from the latched registers.
    - If counter>0, decrement.
    - If counter==0, go to RESP. For a store, mem_WE=1 in this cycle only. For a load, mem_RD is registered into rsp_rdata at this edge.
  - RESP: rsp_valid=1 for exactly one cycle with registered data/flags, req_ready=0, then IDLE.
- Outside ACCESS: mem_modeAddr=000, mem_WE=0, mem_A=0, mem_WD=0. This guarantees no spurious default-mode write.
- Decode, funct3 → modeAddr:
  - 000 LB/SB → 011
  - 001 LH/SH → 010
  - 010 LW/SW → 001
  - 100 LBU → 101
  - 101 LHU → 100
- Illegal: funct3 011/110/111, or a store with 100/101. Raises rsp_illegal; memory is not accessed.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00. Otherwise rsp_misaligned=1, no access. Illegal takes priority over misaligned.
- Latency:
  - Accepting edge at t; rsp_valid high in cycle t+WAIT_CYCLES+2.
  - Error requests respond in cycle t+1.
  - Throughput is one request per WAIT_CYCLES+3 cycles (legal) or 2 cycles (error).
- rsp_rdata/flags hold their value after the RESP cycle until the next response is produced.
- No request is accepted in ACCESS or RESP, even if req_valid is held.
- Reset mid-operation: mem_WE is combinationally gated by !rst, so a store whose commit cycle coincides with rst does not write. The next state is IDLE, no response is issued, and the request is dropped.
- Address 0x100 is passed through like any other; the memory's trigger readback is returned unchanged in rsp_rdata.

Decomposition:
- Package mem_access_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - modeAddr localparams (MODE_NONE=000, MODE_W=001, MODE_H=010, MODE_B=011, MODE_HU=100, MODE_BU=101)
  - state typedef enum {IDLE, ACCESS, RESP}
  - decode function returning {mode, illegal, misaligned}
- No sub-module; single module.

Test Plan:
- WAIT_CYCLES=1, SB addr 0x10003 wdata 0x000000A5. Required: mem_WE high for exactly one cycle, with mem_modeAddr=011 and mem_A=0x10003. Then LBU 0x10003 → rsp_rdata=0x000000A5, and LB 0x10003 → 0xFFFFFFA5, each with rsp_valid 3 cycles after the accept.
- LW addr 0x10002 → rsp_misaligned=1, rsp_rdata=0, mem_WE never asserted, rsp_valid one cycle after the accept. SH addr 0x10001 gives the same result.
- Load funct3=011 → rsp_illegal=1, rsp_misaligned=0, mem_modeAddr stays 000. SB with funct3=100 → rsp_illegal=1.
- LW addr 0x100 with trigger=1 in the memory model → rsp_rdata=0x00000001; with trigger=0 → 0x00000000.
- WAIT_CYCLES=3: SW 0x10010 0xDEADBEEF with rst asserted in the commit cycle → no memory write, no rsp_valid, req_ready=1 the cycle after reset. A following LW 0x10010 returns the prior contents.
- Hold req_valid high across three back-to-back LW requests (WAIT_CYCLES=0) → stall high during ACCESS/RESP, accepts spaced exactly 3 cycles apart, three rsp_valid pulses.
